// File: rtl/audio_pkg.sv
// Shared definitions for the I2S DAC streamer: FSM encoding, channel modes and underrun counter width.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SHIFT      = 2'd2,
    ST_PAD        = 2'd3
  } dac_state_e;

  localparam int UNDERRUN_CNT_W = 16;

  localparam int CH_MONO   = 1;
  localparam int CH_STEREO = 2;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous show-ahead frame FIFO; read data is valid the cycle after a push, pops take effect next edge.
// Pushes when full and pops when empty are dropped; level/full/empty come straight from registered state.
module audio_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign level_o   = level_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/audio_stream_dac.sv
// Buffers PCM frames and serialises them as I2S to a codec-mastered BCLK/LRCK; bits leave ~3 Clk after each BCLK fall.
// in_ready drops when the FIFO is full; AUD_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module audio_stream_dac
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        enable,
  input  logic [NUM_CH*SAMPLE_W-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT,
  output logic                        underrun,
  input  logic                        underrun_clr,
`ifdef AUD_UNDERRUN_CNT_EN
  output logic [UNDERRUN_CNT_W-1:0]   underrun_cnt,
`endif
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        frame_pop
);

  localparam int FW = NUM_CH * SAMPLE_W;
  localparam int CW = $clog2(SAMPLE_W + 1);

  logic [2:0]          bclk_sync_q;
  logic [2:0]          lrck_sync_q;
  logic                bclk_fall;
  logic                lrck_fall;
  logic                lrck_rise;

  dac_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [SAMPLE_W-1:0] right_q, right_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dat_q, dat_d;
  logic                frame_pop_q;
  logic                underrun_q;

  logic                frame_start;
  logic                fifo_pop;
  logic                underrun_set;
  logic [FW-1:0]       fifo_rd;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] left_word;
  logic [SAMPLE_W-1:0] right_word;

  // Bits [1:0] are the two-flop synchroniser, bit [2] the delayed copy for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[1:0], AUD_DACLRCK};
    end
  end

  assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lrck_fall = lrck_sync_q[2] & ~lrck_sync_q[1];
  assign lrck_rise = ~lrck_sync_q[2] & lrck_sync_q[1];

  audio_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .push_i     (in_valid & in_ready),
    .push_dat_i (in_data),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_rd),
    .level_o    (fifo_level),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign in_ready   = ~fifo_full;
  assign left_word  = fifo_rd[FW-1 -: SAMPLE_W];
  assign right_word = (NUM_CH == CH_MONO) ? left_word : fifo_rd[SAMPLE_W-1:0];

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    right_d      = right_q;
    cnt_d        = cnt_q;
    dat_d        = dat_q;
    frame_start  = 1'b0;
    fifo_pop     = 1'b0;
    underrun_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dat_d = 1'b0;
        if (enable) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (lrck_fall) frame_start = 1'b1;
      end
      ST_SHIFT, ST_PAD: begin
        // LRCK edges take priority: any unsent bits of the current word are dropped.
        if (lrck_fall) begin
          frame_start = 1'b1;
        end else if (lrck_rise) begin
          shreg_d = right_q;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else if (bclk_fall) begin
          if (state_q == ST_SHIFT) begin
            dat_d   = shreg_q[SAMPLE_W-1];
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(SAMPLE_W - 1)) state_d = ST_PAD;
          end else begin
            dat_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_start) begin
      cnt_d   = '0;
      state_d = ST_SHIFT;
      if (fifo_empty) begin
        shreg_d      = '0;
        right_d      = '0;
        underrun_set = 1'b1;
      end else begin
        shreg_d  = left_word;
        right_d  = right_word;
        fifo_pop = 1'b1;
      end
    end

    if (!enable) begin
      state_d      = ST_IDLE;
      dat_d        = 1'b0;
      fifo_pop     = 1'b0;
      underrun_set = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      right_q     <= '0;
      cnt_q       <= '0;
      dat_q       <= 1'b0;
      frame_pop_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      right_q     <= right_d;
      cnt_q       <= cnt_d;
      dat_q       <= dat_d;
      frame_pop_q <= fifo_pop;
      underrun_q  <= underrun_set | (underrun_q & ~underrun_clr);
    end
  end

  assign AUD_DACDAT = dat_q;
  assign frame_pop  = frame_pop_q;
  assign underrun   = underrun_q;

`ifdef AUD_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_set) begin
      if (underrun_clr)    ucnt_d = UNDERRUN_CNT_W'(1);
      else if (ucnt_q != '1) ucnt_d = ucnt_q + UNDERRUN_CNT_W'(1);
    end else if (underrun_clr) begin
      ucnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_audio_stream_dac.sv
// Bench for audio_stream_dac: a stereo 16-bit instance and a mono 24-bit instance share one I2S clock pair.
`timescale 1ns/1ps
module tb_audio_stream_dac;
  import audio_pkg::*;

  localparam int SLOT = 32;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset, bclk, lrck;
  logic        en0, vld0, rdy0, dat0, ur0, clr0, pop0;
  logic [31:0] din0;
  logic [3:0]  lvl0;
  logic        en1, vld1, rdy1, dat1, ur1, clr1, pop1;
  logic [23:0] din1;
  logic [2:0]  lvl1;
`ifdef AUD_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ucnt0, ucnt1;
`endif

  audio_stream_dac #(.SAMPLE_W(16), .NUM_CH(2), .DEPTH(8)) u0 (
    .Clk(Clk), .Reset(Reset), .enable(en0), .in_data(din0), .in_valid(vld0), .in_ready(rdy0),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat0), .underrun(ur0), .underrun_clr(clr0),
`ifdef AUD_UNDERRUN_CNT_EN
    .underrun_cnt(ucnt0),
`endif
    .fifo_level(lvl0), .frame_pop(pop0));

  audio_stream_dac #(.SAMPLE_W(24), .NUM_CH(1), .DEPTH(4)) u1 (
    .Clk(Clk), .Reset(Reset), .enable(en1), .in_data(din1), .in_valid(vld1), .in_ready(rdy1),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat1), .underrun(ur1), .underrun_clr(clr1),
`ifdef AUD_UNDERRUN_CNT_EN
    .underrun_cnt(ucnt1),
`endif
    .fifo_level(lvl1), .frame_pop(pop1));

  int errs = 0;
  int checks = 0;
  int pops0 = 0;
  logic [31:0] mq[$];

  always @(posedge Clk) if (pop0 === 1'b1) pops0++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // Expected slot as captured once per BCLK period: one delay bit, the word MSB-first, then zero padding.
  function automatic logic [31:0] slot_of(input logic [31:0] w, input int width);
    return w << (SLOT - 1 - width);
  endfunction

  task automatic run_slot(input logic lr, input int n, output logic [31:0] c0, output logic [31:0] c1);
    c0 = '0;
    c1 = '0;
    for (int b = 0; b < n; b++) begin
      lrck = lr;
      bclk = 1'b0;
      #40;
      bclk = 1'b1;
      #40;
      c0 = {c0[30:0], dat0};
      c1 = {c1[30:0], dat1};
    end
  endtask

  task automatic run_frame(output logic [31:0] l0, output logic [31:0] r0,
                           output logic [31:0] l1, output logic [31:0] r1);
    run_slot(1'b0, SLOT, l0, l1);
    run_slot(1'b1, SLOT, r0, r1);
  endtask

  task automatic push0(input logic [31:0] d);
    vld0 = 1'b1;
    din0 = d;
    step();
    vld0 = 1'b0;
  endtask

  task automatic push1(input logic [23:0] d);
    vld1 = 1'b1;
    din1 = d;
    step();
    vld1 = 1'b0;
  endtask

  // LRCK falls, optionally presenting a push in the cycle the frame is consumed; ends just after that edge.
  task automatic lr_fall_seq(input logic do_push, input logic [31:0] d);
    lrck = 1'b0;
    bclk = 1'b0;
    step();
    step();
    if (do_push) begin
      vld0 = 1'b1;
      din0 = d;
    end
    step();
    vld0 = 1'b0;
  endtask

  task automatic idle_high();
    lrck = 1'b1;
    bclk = 1'b1;
    repeat (6) step();
  endtask

  typedef struct {
    logic [31:0] din;
    logic [15:0] l;
    logic [15:0] r;
  } st_vec_t;

  typedef struct {
    logic [23:0] din;
    logic [23:0] w;
  } mono_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    st_vec_t     tv[4];
    mono_vec_t   mv[2];
    logic [31:0] l0, r0, l1, r1, w, d;
    logic        exp_ur;
    int          p, n, m;

    tv[0] = '{32'h8001_7FFE, 16'h8001, 16'h7FFE};
    tv[1] = '{32'hFFFF_0000, 16'hFFFF, 16'h0000};
    tv[2] = '{32'h0001_8000, 16'h0001, 16'h8000};
    tv[3] = '{32'hA5C3_3C5A, 16'hA5C3, 16'h3C5A};
    mv[0] = '{24'hA5A5A5, 24'hA5A5A5};
    mv[1] = '{24'h80_0001, 24'h80_0001};

    Reset = 1'b1; bclk = 1'b1; lrck = 1'b1;
    en0 = 1'b0; vld0 = 1'b0; din0 = '0; clr0 = 1'b0;
    en1 = 1'b0; vld1 = 1'b0; din1 = '0; clr1 = 1'b0;
    repeat (3) step();
    chk("rst_level", lvl0, 0);
    chk("rst_ready", rdy0, 1);
    chk("rst_dacdat", dat0, 0);
    chk("rst_underrun", ur0, 0);
    chk("rst_frame_pop", pop0, 0);
    Reset = 1'b0;
    step();

    // Stereo table: push four frames, then stream them.
    for (int i = 0; i < 4; i++) push0(tv[i].din);
    chk("tbl_level", lvl0, 4);
    p = pops0;
    en0 = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      run_frame(l0, r0, l1, r1);
      chk($sformatf("tbl_left%0d", i), l0, slot_of(32'(tv[i].l), 16));
      chk($sformatf("tbl_right%0d", i), r0, slot_of(32'(tv[i].r), 16));
    end
    chk("tbl_pops", pops0 - p, 4);
    chk("tbl_level_end", lvl0, 0);
    chk("tbl_no_underrun", ur0, 0);

    // Underrun on empty FIFO.
    p = pops0;
    run_frame(l0, r0, l1, r1);
    chk("ur_left_zero", l0, 0);
    chk("ur_right_zero", r0, 0);
    chk("ur_set", ur0, 1);
    chk("ur_no_pop", pops0 - p, 0);
    clr0 = 1'b1; step(); clr0 = 1'b0; step();
    chk("ur_cleared", ur0, 0);
`ifdef AUD_UNDERRUN_CNT_EN
    clr0 = 1'b1; step(); clr0 = 1'b0;
    for (int i = 0; i < 3; i++) run_frame(l0, r0, l1, r1);
    chk("ucnt_three", ucnt0, 3);
    clr0 = 1'b1; step(); clr0 = 1'b0; step();
    chk("ucnt_clear", ucnt0, 0);
`endif
    clr0 = 1'b1;
    lr_fall_seq(1'b0, 32'h0);
    chk("ur_set_beats_clr", ur0, 1);
    step();
    chk("ur_clr_after", ur0, 0);
    clr0 = 1'b0;
    en0 = 1'b0;
    idle_high();

    // Full FIFO, ignored push, simultaneous push/pop.
    for (int i = 0; i < 8; i++) begin
      d = 32'hF000_0000 | $urandom();
      push0(d);
      mq.push_back(d);
    end
    chk("full_ready", rdy0, 0);
    chk("full_level", lvl0, 8);
    push0(32'h1234_5678);
    chk("full_ninth_ignored", lvl0, 8);
    en0 = 1'b1;
    step();
    run_frame(l0, r0, l1, r1);
    w = mq.pop_front();
    chk("full_left", l0, slot_of(32'(w[31:16]), 16));
    chk("full_right", r0, slot_of(32'(w[15:0]), 16));
    chk("full_level_7", lvl0, 7);
    d = $urandom();
    lr_fall_seq(1'b1, d);
    w = mq.pop_front();
    mq.push_back(d);
    chk("simul_level", lvl0, 7);
    chk("simul_frame_pop", pop0, 1);
    step();
    chk("frame_pop_pulse", pop0, 0);
    run_slot(1'b0, 5, l0, l1);
    chk("pre_rst_msbs", l0[3:0], w[31:28]);

    // Mid-frame reset.
    Reset = 1'b1;
    step();
    chk("mrst_dacdat", dat0, 0);
    chk("mrst_level", lvl0, 0);
    chk("mrst_ready", rdy0, 1);
    chk("mrst_underrun", ur0, 0);
    chk("mrst_frame_pop", pop0, 0);
    Reset = 1'b0;
    mq.delete();
    push0(32'hC3C3_5A5A);
    run_slot(1'b0, 27, l0, l1);
    chk("mrst_rest_left_zero", l0, 0);
    run_slot(1'b1, SLOT, r0, r1);
    chk("mrst_rest_right_zero", r0, 0);
    run_frame(l0, r0, l1, r1);
    chk("mrst_resume_left", l0, slot_of(32'h0000_C3C3, 16));
    chk("mrst_resume_right", r0, slot_of(32'h0000_5A5A, 16));

    // Enable drop mid-word.
    push0(32'hF800_1111);
    push0(32'h2222_3333);
    run_slot(1'b0, 6, l0, l1);
    chk("en_pre_bits", l0[5:0], 6'b011111);
    en0 = 1'b0;
    step();
    chk("en_drop_dacdat", dat0, 0);
    chk("en_drop_level", lvl0, 1);
    en0 = 1'b1;
    run_slot(1'b0, 26, l0, l1);
    chk("en_rest_left_zero", l0, 0);
    run_slot(1'b1, SLOT, r0, r1);
    chk("en_rest_right_zero", r0, 0);
    run_frame(l0, r0, l1, r1);
    chk("en_resume_left", l0, slot_of(32'h0000_2222, 16));
    chk("en_resume_right", r0, slot_of(32'h0000_3333, 16));

    // Mono 24-bit table on the second instance.
    en0 = 1'b0;
    for (int i = 0; i < 2; i++) push1(mv[i].din);
    en1 = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      run_frame(l0, r0, l1, r1);
      chk($sformatf("mono_left%0d", i), l1, slot_of(32'(mv[i].w), 24));
      chk($sformatf("mono_right%0d", i), r1, slot_of(32'(mv[i].w), 24));
    end
    chk("mono_level", lvl1, 0);
    chk("mono_no_underrun", ur1, 0);
    en1 = 1'b0;

    // Random pushes and frames against a queue model.
    en0 = 1'b1;
    step();
    for (int r = 0; r < 6; r++) begin
      exp_ur = 1'b0;
      clr0 = 1'b1; step(); clr0 = 1'b0;
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        d = $urandom();
        chk("rnd_ready", rdy0, (mq.size() != 8) ? 1 : 0);
        push0(d);
        if (mq.size() < 8) mq.push_back(d);
      end
      m = $urandom_range(1, 3);
      for (int f = 0; f < m; f++) begin
        run_frame(l0, r0, l1, r1);
        if (mq.size() > 0) begin
          w = mq.pop_front();
        end else begin
          w = '0;
          exp_ur = 1'b1;
        end
        chk("rnd_left", l0, slot_of(32'(w[31:16]), 16));
        chk("rnd_right", r0, slot_of(32'(w[15:0]), 16));
      end
      chk("rnd_level", lvl0, mq.size());
      chk("rnd_underrun", ur0, exp_ur);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
